xadc_drp_sequencer: RTL and testbench

Sits directly upstream of the XADC primitive's DRP port and owns it exclusively. It arbitrates between one-shot host DRP transactions, issued by the register front-end, and an autonomous periodic poll of the temperature, VCCINT and VCCAUX status registers. It publishes the latest 12-bit readings plus a peak-temperature latch for the register map and the fan/thermal logic. Every DRP transaction is covered by a DRDY timeout.

---
 rtl/xadc_drp_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_sequencer.sv
// Sole owner of the XADC DRP port: arbitrates one-shot host transactions against a
// periodic temperature/VCCINT/VCCAUX poll, with a DRDY timeout on every access.
module xadc_drp_sequencer #(
   parameter logic [23:0] pPOLL_PERIOD = 24'd1000000,
   parameter logic [7:0]  pTIMEOUT     = 8'd255,
   parameter logic [6:0]  pADDR_TEMP   = 7'h00,
   parameter logic [6:0]  pADDR_VCCINT = 7'h01,
   parameter logic [6:0]  pADDR_VCCAUX = 7'h02
) (
   input  logic        clk_usb,
   input  logic        reset_i,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [6:0]  host_addr,
   input  logic [15:0] host_din,
   output logic        host_busy,
   output logic        host_done,
   output logic        host_timeout,
   output logic [15:0] host_dout,
   input  logic        poll_enable,
   input  logic        temp_max_clear,
   output logic [11:0] temp_raw,
   output logic [11:0] vccint_raw,
   output logic [11:0] vccaux_raw,
   output logic [11:0] temp_max,
   output logic        poll_valid,
   output logic        poll_err,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [6:0]  drp_addr,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;

   state_t      state, state_nxt;
   logic        host_pending, host_active, poll_pending;
   logic        req_we, cur_we;
   logic [6:0]  req_addr;
   logic [15:0] req_din;
   logic [23:0] poll_cnt;
   logic [7:0]  wait_cnt;
   logic [1:0]  poll_idx;
   logic        poll_wrap, wait_expired, start_host, start_poll, temp_capture;
   logic [11:0] code;

   function automatic logic [6:0] poll_addr(input logic [1:0] idx);
      case (idx)
         2'd0:    return pADDR_TEMP;
         2'd1:    return pADDR_VCCINT;
         default: return pADDR_VCCAUX;
      endcase
   endfunction

   assign poll_wrap    = poll_enable && (poll_cnt == pPOLL_PERIOD - 24'd1);
   assign wait_expired = (wait_cnt == pTIMEOUT - 8'd1);
   assign code         = drp_do[15:4];
   assign temp_capture = (state == WAIT) && drp_drdy && !host_active && (poll_idx == 2'd0);
   assign host_busy    = host_pending || host_active;
   assign drp_den      = (state == ISSUE);
   assign drp_dwe      = (state == ISSUE) && cur_we;

   always_ff @(posedge clk_usb) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nxt;
   end

   // Host wins a tie with a pending poll; a running poll sequence is never interrupted.
   always_comb begin
      state_nxt  = state;
      start_host = 1'b0;
      start_poll = 1'b0;
      case (state)
         IDLE: begin
            if (host_pending) begin
               state_nxt  = ISSUE;
               start_host = 1'b1;
            end else if (poll_pending) begin
               state_nxt  = ISSUE;
               start_poll = 1'b1;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (drp_drdy)          state_nxt = host_active ? IDLE : NEXT;
            else if (wait_expired) state_nxt = IDLE;
         end
         NEXT:    state_nxt = (poll_idx == 2'd2) ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         host_pending <= 1'b0;
         host_active  <= 1'b0;
         poll_pending <= 1'b0;
         req_we       <= 1'b0;
         req_addr     <= '0;
         req_din      <= '0;
         cur_we       <= 1'b0;
         poll_cnt     <= '0;
         wait_cnt     <= '0;
         poll_idx     <= '0;
         host_done    <= 1'b0;
         host_timeout <= 1'b0;
         host_dout    <= '0;
         temp_raw     <= '0;
         vccint_raw   <= '0;
         vccaux_raw   <= '0;
         temp_max     <= '0;
         poll_valid   <= 1'b0;
         poll_err     <= 1'b0;
         drp_addr     <= '0;
         drp_di       <= '0;
      end else begin
         host_done    <= 1'b0;
         host_timeout <= 1'b0;

         if (!poll_enable || poll_wrap) poll_cnt <= '0;
         else                           poll_cnt <= poll_cnt + 24'd1;

         // The pending flag is consumed at launch so wraps during a sequence queue one more.
         if (poll_wrap)       poll_pending <= 1'b1;
         else if (start_poll) poll_pending <= 1'b0;

         if (host_req && !host_busy) begin
            host_pending <= 1'b1;
            req_we       <= host_we;
            req_addr     <= host_addr;
            req_din      <= host_din;
         end

         if (start_host) begin
            host_pending <= 1'b0;
            host_active  <= 1'b1;
            cur_we       <= req_we;
            drp_addr     <= req_addr;
            drp_di       <= req_din;
         end else if (start_poll) begin
            poll_idx <= 2'd0;
            cur_we   <= 1'b0;
            drp_addr <= pADDR_TEMP;
            drp_di   <= '0;
         end else if (state == NEXT && poll_idx != 2'd2) begin
            poll_idx <= poll_idx + 2'd1;
            drp_addr <= poll_addr(poll_idx + 2'd1);
         end

         if (state == NEXT && poll_idx == 2'd2) poll_valid <= 1'b1;

         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;

         if (state == WAIT) begin
            if (drp_drdy) begin
               if (host_active) begin
                  host_done   <= 1'b1;
                  host_active <= 1'b0;
                  if (!cur_we) host_dout <= drp_do;
               end else begin
                  case (poll_idx)
                     2'd0:    temp_raw   <= code;
                     2'd1:    vccint_raw <= code;
                     default: vccaux_raw <= code;
                  endcase
               end
            end else if (wait_expired) begin
               if (host_active) begin
                  host_timeout <= 1'b1;
                  host_active  <= 1'b0;
               end else begin
                  poll_err <= 1'b1;
               end
            end
         end

         if (temp_capture) begin
            if (temp_max_clear || code > temp_max) temp_max <= code;
         end else if (temp_max_clear) begin
            temp_max <= '0;
         end
      end
   end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer: a DRP responder plays back expected transactions while a
// transaction-level model of the published registers is compared every cycle.
module tb_xadc_drp_sequencer;

   localparam int TMO = 10;

   logic        clk_usb, reset_i;
   logic        host_req, host_we;
   logic [6:0]  host_addr;
   logic [15:0] host_din;
   logic        host_busy, host_done, host_timeout;
   logic [15:0] host_dout;
   logic        poll_enable, temp_max_clear;
   logic [11:0] temp_raw, vccint_raw, vccaux_raw, temp_max;
   logic        poll_valid, poll_err;
   logic        drp_den, drp_dwe;
   logic [6:0]  drp_addr;
   logic [15:0] drp_di, drp_do;
   logic        drp_drdy;

   xadc_drp_sequencer #(
      .pPOLL_PERIOD(24'd16),
      .pTIMEOUT    (8'd10),
      .pADDR_TEMP  (7'h00),
      .pADDR_VCCINT(7'h01),
      .pADDR_VCCAUX(7'h02)
   ) dut (
      .clk_usb       (clk_usb),
      .reset_i       (reset_i),
      .host_req      (host_req),
      .host_we       (host_we),
      .host_addr     (host_addr),
      .host_din      (host_din),
      .host_busy     (host_busy),
      .host_done     (host_done),
      .host_timeout  (host_timeout),
      .host_dout     (host_dout),
      .poll_enable   (poll_enable),
      .temp_max_clear(temp_max_clear),
      .temp_raw      (temp_raw),
      .vccint_raw    (vccint_raw),
      .vccaux_raw    (vccaux_raw),
      .temp_max      (temp_max),
      .poll_valid    (poll_valid),
      .poll_err      (poll_err),
      .drp_den       (drp_den),
      .drp_dwe       (drp_dwe),
      .drp_addr      (drp_addr),
      .drp_di        (drp_di),
      .drp_do        (drp_do),
      .drp_drdy      (drp_drdy)
   );

   typedef struct {
      bit          is_host;
      bit          we;
      logic [6:0]  addr;
      logic [15:0] di;
      int          delay;
      logic [15:0] data;
      bit          respond;
      bit          chk_lat;
   } txn_t;

   txn_t        expq[$];
   int          nChecks = 0, nFail = 0;
   int          cyc = 0;
   bit          cmp_en = 0, resp_active = 0, resp_abort = 0, stray_req = 0;
   int          last_req_cyc = -1, last_den_cyc = -1, last_drdy_cyc = -1;
   int          last_done_cyc = -1, last_to_cyc = -1;

   bit          m_busy, m_err;
   logic [15:0] m_dout;
   logic [11:0] m_temp, m_vint, m_vaux, m_tmax;
   int          m_valid_from, m_done_cyc, m_to_cyc;

   initial begin
      clk_usb = 1'b0;
      forever #5 clk_usb = ~clk_usb;
   end

   initial forever begin
      @(posedge clk_usb);
      cyc++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic resetModel();
      m_busy = 0; m_err = 0; m_dout = '0;
      m_temp = '0; m_vint = '0; m_vaux = '0; m_tmax = '0;
      m_valid_from = 32'h7fffffff; m_done_cyc = -1; m_to_cyc = -1;
      expq.delete();
   endtask

   task automatic expectTxn(input bit is_host, input bit we, input logic [6:0] addr,
                            input logic [15:0] di, input int delay, input logic [15:0] data,
                            input bit respond, input bit chk_lat);
      txn_t t;
      t.is_host = is_host; t.we = we; t.addr = addr; t.di = di;
      t.delay = delay; t.data = data; t.respond = respond; t.chk_lat = chk_lat;
      expq.push_back(t);
   endtask

   // Register-map effect of a completed DRP access, visible from the current cycle.
   task automatic modelComplete(input txn_t t);
      logic [11:0] c;
      c = t.data[15:4];
      if (t.is_host) begin
         m_done_cyc = cyc;
         m_busy = 0;
         if (!t.we) m_dout = t.data;
      end else if (t.addr == 7'h00) begin
         m_temp = c;
         if (c > m_tmax) m_tmax = c;
      end else if (t.addr == 7'h01) begin
         m_vint = c;
      end else begin
         m_vaux = c;
         if (m_valid_from > cyc + 1) m_valid_from = cyc + 1;
      end
   endtask

   task automatic modelTimeout(input txn_t t);
      if (t.is_host) begin
         m_to_cyc = cyc;
         m_busy = 0;
      end else begin
         m_err = 1;
      end
   endtask

   // DRP responder: each den must match the head of the expected queue.
   initial begin : responder
      txn_t t;
      bit   aborted;
      bit   stray_served;
      stray_served = 0;
      drp_drdy = 1'b0;
      drp_do   = '0;
      forever begin
         @(negedge clk_usb);
         if (stray_req && !stray_served) begin
            @(posedge clk_usb); #2;
            drp_drdy = 1'b1; drp_do = 16'hDEA0;
            @(posedge clk_usb); #2;
            drp_drdy = 1'b0; drp_do = '0;
            stray_served = 1;
         end else if (drp_den === 1'b1 && reset_i === 1'b0) begin
            if (expq.size() == 0) begin
               nChecks++; nFail++;
               $display("[TB] FAIL unexpected_den: got addr 0x%0h we %0b, required no transaction (cycle %0d)",
                        drp_addr, drp_dwe, cyc);
            end else begin
               t = expq.pop_front();
               last_den_cyc = cyc;
               resp_active = 1;
               aborted = 0;
               checkOutput("den_we", 32'(drp_dwe), 32'(t.we));
               checkOutput("den_addr", 32'(drp_addr), 32'(t.addr));
               if (t.we) checkOutput("den_di", 32'(drp_di), 32'(t.di));
               if (t.chk_lat) checkOutput("den_latency", 32'(last_den_cyc - last_req_cyc), 32'd2);
               if (t.respond) begin
                  for (int k = 0; k < t.delay; k++) begin
                     @(posedge clk_usb); #2;
                     if (resp_abort) aborted = 1;
                  end
                  if (!aborted) begin
                     checkOutput("addr_hold", 32'(drp_addr), 32'(t.addr));
                     drp_drdy = 1'b1; drp_do = t.data; last_drdy_cyc = cyc;
                     @(posedge clk_usb); #2;
                     drp_drdy = 1'b0; drp_do = '0;
                     if (!resp_abort) modelComplete(t);
                  end
               end else begin
                  for (int k = 0; k < TMO + 1; k++) begin
                     @(posedge clk_usb); #2;
                     if (resp_abort) aborted = 1;
                  end
                  if (!aborted) modelTimeout(t);
               end
               resp_active = 0;
            end
         end
      end
   end

   // Every-cycle comparison of all host-visible outputs against the model.
   initial begin : compare
      forever begin
         @(negedge clk_usb);
         if (cmp_en) begin
            checkOutput("host_busy", 32'(host_busy), 32'(m_busy));
            checkOutput("host_done", 32'(host_done), 32'(cyc == m_done_cyc));
            checkOutput("host_timeout", 32'(host_timeout), 32'(cyc == m_to_cyc));
            checkOutput("host_dout", 32'(host_dout), 32'(m_dout));
            checkOutput("temp_raw", 32'(temp_raw), 32'(m_temp));
            checkOutput("vccint_raw", 32'(vccint_raw), 32'(m_vint));
            checkOutput("vccaux_raw", 32'(vccaux_raw), 32'(m_vaux));
            checkOutput("temp_max", 32'(temp_max), 32'(m_tmax));
            checkOutput("poll_valid", 32'(poll_valid), 32'(cyc >= m_valid_from));
            checkOutput("poll_err", 32'(poll_err), 32'(m_err));
            if (host_done === 1'b1) last_done_cyc = cyc;
            if (host_timeout === 1'b1) last_to_cyc = cyc;
         end
      end
   end

   task automatic applyStimulus(input bit we, input logic [6:0] addr, input logic [15:0] din);
      bit acc;
      int rc;
      @(posedge clk_usb); #1;
      host_req = 1'b1; host_we = we; host_addr = addr; host_din = din;
      rc = cyc;
      @(negedge clk_usb);
      acc = !m_busy;
      @(posedge clk_usb); #1;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
      if (acc) begin
         m_busy = 1;
         last_req_cyc = rc;
      end
   endtask

   task automatic setPoll(input bit en);
      @(posedge clk_usb); #1;
      poll_enable = en;
   endtask

   task automatic waitIdle(input int budget, input string tag);
      int n;
      n = 0;
      while ((expq.size() != 0 || resp_active) && n < budget) begin
         @(posedge clk_usb); #3;
         n++;
      end
      nChecks++;
      if (expq.size() != 0 || resp_active) begin
         nFail++;
         $display("[TB] FAIL %s_wait: got %0d transactions outstanding after %0d cycles, required 0",
                  tag, expq.size(), budget);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int saved;
      int n;
      reset_i = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
      poll_enable = 1'b0; temp_max_clear = 1'b0;
      resetModel();
      repeat (3) @(posedge clk_usb);
      #1 cmp_en = 1;
      @(posedge clk_usb); #1 reset_i = 1'b0;
      @(negedge clk_usb);
      checkOutput("rst_den", 32'(drp_den), 32'd0);
      checkOutput("rst_addr", 32'(drp_addr), 32'd0);
      checkOutput("rst_busy", 32'(host_busy), 32'd0);

      $display("[TB] host read");
      expectTxn(1, 0, 7'h00, 16'h0000, 3, 16'hA5A0, 1, 1);
      applyStimulus(0, 7'h00, 16'h0000);
      waitIdle(40, "read");
      @(negedge clk_usb); #1;
      checkOutput("read_dout", 32'(host_dout), 32'h0000A5A0);
      checkOutput("read_done_lat", 32'(last_done_cyc - last_drdy_cyc), 32'd1);

      $display("[TB] host write");
      expectTxn(1, 1, 7'h41, 16'h2F00, 2, 16'h0000, 1, 1);
      applyStimulus(1, 7'h41, 16'h2F00);
      waitIdle(40, "write");
      @(negedge clk_usb); #1;
      checkOutput("write_dout_kept", 32'(host_dout), 32'h0000A5A0);

      $display("[TB] periodic poll");
      expectTxn(0, 0, 7'h00, 16'h0, 2, 16'h9990, 1, 0);
      expectTxn(0, 0, 7'h01, 16'h0, 2, 16'h5550, 1, 0);
      expectTxn(0, 0, 7'h02, 16'h0, 2, 16'h9990, 1, 0);
      setPoll(1);
      waitIdle(60, "poll1");
      expectTxn(0, 0, 7'h00, 16'h0, 2, 16'h7770, 1, 0);
      expectTxn(0, 0, 7'h01, 16'h0, 2, 16'h5550, 1, 0);
      expectTxn(0, 0, 7'h02, 16'h0, 2, 16'h9990, 1, 0);
      repeat (2) @(negedge clk_usb);
      checkOutput("poll1_temp", 32'(temp_raw), 32'h999);
      checkOutput("poll1_vccint", 32'(vccint_raw), 32'h555);
      checkOutput("poll1_vccaux", 32'(vccaux_raw), 32'h999);
      checkOutput("poll1_valid", 32'(poll_valid), 32'd1);
      waitIdle(60, "poll2");
      setPoll(0);
      @(negedge clk_usb);
      checkOutput("poll2_temp", 32'(temp_raw), 32'h777);
      checkOutput("poll2_tmax", 32'(temp_max), 32'h999);

      $display("[TB] host vs poll arbitration");
      expectTxn(1, 0, 7'h10, 16'h0, 2, 16'h1230, 1, 1);
      expectTxn(0, 0, 7'h00, 16'h0, 2, 16'h1110, 1, 0);
      expectTxn(0, 0, 7'h01, 16'h0, 2, 16'h2220, 1, 0);
      expectTxn(0, 0, 7'h02, 16'h0, 2, 16'h3330, 1, 0);
      expectTxn(1, 0, 7'h20, 16'h0, 2, 16'hBEEF, 1, 0);
      setPoll(1);
      repeat (14) @(posedge clk_usb);
      applyStimulus(0, 7'h10, 16'h0000);
      repeat (5) @(posedge clk_usb);
      setPoll(0);
      applyStimulus(0, 7'h20, 16'h0000);
      applyStimulus(1, 7'h30, 16'h1234);
      waitIdle(80, "arb");
      @(negedge clk_usb);
      checkOutput("arb_dout", 32'(host_dout), 32'h0000BEEF);
      checkOutput("arb_tmax", 32'(temp_max), 32'h999);

      $display("[TB] temp_max clear");
      @(posedge clk_usb); #1 temp_max_clear = 1'b1;
      @(posedge clk_usb); #1 temp_max_clear = 1'b0;
      m_tmax = '0;
      @(negedge clk_usb);
      checkOutput("clear_tmax", 32'(temp_max), 32'd0);

      $display("[TB] host timeout");
      expectTxn(1, 0, 7'h05, 16'h0, 0, 16'h0, 0, 1);
      applyStimulus(0, 7'h05, 16'h0000);
      waitIdle(60, "host_to");
      @(negedge clk_usb); #1;
      checkOutput("host_to_lat", 32'(last_to_cyc - last_den_cyc), 32'(TMO + 1));
      checkOutput("host_to_busy", 32'(host_busy), 32'd0);

      $display("[TB] poll timeout");
      expectTxn(0, 0, 7'h00, 16'h0, 0, 16'h0, 0, 0);
      setPoll(1);
      waitIdle(60, "poll_to");
      setPoll(0);
      repeat (6) @(negedge clk_usb);
      checkOutput("poll_to_err", 32'(poll_err), 32'd1);

      $display("[TB] reset during wait");
      expectTxn(1, 0, 7'h06, 16'h0, 0, 16'h0, 0, 1);
      applyStimulus(0, 7'h06, 16'h0000);
      n = 0;
      while (!resp_active && n < 20) begin
         @(posedge clk_usb); #3;
         n++;
      end
      checkOutput("rst_wait_entered", 32'(resp_active), 32'd1);
      repeat (2) @(posedge clk_usb);
      #1 reset_i = 1'b1; resp_abort = 1;
      @(posedge clk_usb); #1;
      resetModel();
      reset_i = 1'b0;
      @(negedge clk_usb);
      checkOutput("rst2_err", 32'(poll_err), 32'd0);
      checkOutput("rst2_dout", 32'(host_dout), 32'd0);
      checkOutput("rst2_temp", 32'(temp_raw), 32'd0);
      checkOutput("rst2_busy", 32'(host_busy), 32'd0);
      @(posedge clk_usb); #1 resp_abort = 0;
      waitIdle(40, "abort");
      saved = last_done_cyc;
      stray_req = 1;
      repeat (6) @(posedge clk_usb);
      @(negedge clk_usb);
      checkOutput("stray_no_done", 32'(last_done_cyc), 32'(saved));
      checkOutput("stray_busy", 32'(host_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
